// File: rtl/tmem_bank_scheduler_pkg.sv
// Shared definitions for the per-bank TMEM read scheduler.
// Core-count defaults, hold limit, FSM encoding and stats width.
package tmem_bank_scheduler_pkg;

  localparam int TMEM_NUM_CORES = 4;
  localparam int TMEM_CORE_BITS = 2;
  localparam int TMEM_MAX_HOLD  = 4;
  localparam int TMEM_STAT_W    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/tmem_bank_scheduler_rr_priority_pick.sv
// Combinational rotating-priority picker: first request at or above
// ptr_i (with wrap) that is not masked by excl_i.
module rr_priority_pick
  import tmem_bank_scheduler_pkg::*;
#(
  parameter int NUM_CORES = TMEM_NUM_CORES,
  parameter int CORE_BITS = TMEM_CORE_BITS
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [CORE_BITS-1:0] ptr_i,
  input  logic [NUM_CORES-1:0] excl_i,
  output logic [NUM_CORES-1:0] sel_o,
  output logic [CORE_BITS-1:0] idx_o,
  output logic                 found_o
);

  localparam int IW = CORE_BITS + 1;
  localparam logic [IW-1:0] N_W = IW'(NUM_CORES);

  logic [NUM_CORES-1:0] cand;
  logic [NUM_CORES-1:0] rot;
  logic [IW-1:0]        sum;

  assign cand = req_i & ~excl_i;

  // Rotate so that bit 0 of rot is the core at the pointer.
  assign rot = (cand >> ptr_i)
             | (cand << (N_W - {1'b0, ptr_i}));

  always_comb begin
    found_o = 1'b0;
    sum     = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        sum     = {1'b0, ptr_i} + IW'(i);
      end
    end
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    idx_o = sum[CORE_BITS-1:0];
  end

  assign sel_o = found_o ?
                 (NUM_CORES'(1) << idx_o) : '0;

endmodule

// File: rtl/tmem_bank_scheduler.sv
// Per-bank TMEM read scheduler: round-robin with bounded hold time.
// Optional stats counters enabled by TMEM_SCHED_STATS_EN.
module tmem_bank_scheduler
  import tmem_bank_scheduler_pkg::*;
#(
  parameter int NUM_CORES = TMEM_NUM_CORES,
  parameter int CORE_BITS = TMEM_CORE_BITS,
  parameter int MAX_HOLD  = TMEM_MAX_HOLD
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iEnable,
  input  logic [NUM_CORES-1:0]   iRequest,
`ifdef TMEM_SCHED_STATS_EN
  input  logic                   iStatClear,
  output logic [TMEM_STAT_W-1:0] oConflictCount,
  output logic [TMEM_STAT_W-1:0] oForcedRotations,
`endif
  output logic [NUM_CORES-1:0]   oGrant,
  output logic [CORE_BITS-1:0]   oBusSelect,
  output logic                   oGrantValid
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(MAX_HOLD);
  localparam logic [CORE_BITS-1:0] LAST =
    CORE_BITS'(NUM_CORES - 1);

  sched_state_e         state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [CORE_BITS-1:0] sel_q, sel_d;
  logic [CORE_BITS-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 valid_q;

  logic [CORE_BITS-1:0] k_next;
  logic [CORE_BITS-1:0] pick_ptr;
  logic [NUM_CORES-1:0] pick_excl;
  logic [NUM_CORES-1:0] pick_sel;
  logic [CORE_BITS-1:0] pick_idx;
  logic                 pick_found;
  logic                 own_req;
  logic                 others;
  logic                 rotate;

  function automatic logic [CORE_BITS-1:0] inc_idx(
    input logic [CORE_BITS-1:0] k
  );
    if (k == LAST) begin
      return '0;
    end
    return k + 1'b1;
  endfunction

  assign k_next  = inc_idx(sel_q);
  assign own_req = |(iRequest & grant_q);
  assign others  = |(iRequest & ~grant_q);

  // In GRANT the holder is excluded so it gets the lowest priority.
  assign pick_ptr  = (state_q == ST_GRANT) ? k_next : ptr_q;
  assign pick_excl = (state_q == ST_GRANT) ? grant_q : '0;

  assign rotate = (state_q == ST_GRANT) && own_req &&
                  iEnable && others &&
                  (hold_q == HOLD_MAX);

  rr_priority_pick #(
    .NUM_CORES (NUM_CORES),
    .CORE_BITS (CORE_BITS)
  ) u_pick (
    .req_i   (iRequest),
    .ptr_i   (pick_ptr),
    .excl_i  (pick_excl),
    .sel_o   (pick_sel),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iEnable && pick_found) begin
          state_d = ST_GRANT;
          grant_d = pick_sel;
          sel_d   = pick_idx;
          hold_d  = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (!own_req) begin
          ptr_d = k_next;
          if (iEnable && pick_found) begin
            grant_d = pick_sel;
            sel_d   = pick_idx;
            hold_d  = HOLD_W'(1);
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (rotate) begin
          ptr_d   = k_next;
          grant_d = pick_sel;
          sel_d   = pick_idx;
          hold_d  = HOLD_W'(1);
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      valid_q <= |grant_d;
    end
  end

  assign oGrant      = grant_q;
  assign oBusSelect  = sel_q;
  assign oGrantValid = valid_q;

`ifdef TMEM_SCHED_STATS_EN
  logic [TMEM_STAT_W-1:0] conf_q;
  logic [TMEM_STAT_W-1:0] forced_q;
  logic                   multi_req;

  // Clearing the lowest set bit leaves non-zero iff >= 2 bits set.
  assign multi_req = |(iRequest & (iRequest - 1'b1));

  always_ff @(posedge Clock) begin
    if (!Reset || iStatClear) begin
      conf_q   <= '0;
      forced_q <= '0;
    end else begin
      if (multi_req && (conf_q != '1)) begin
        conf_q <= conf_q + 1'b1;
      end
      if (rotate && (forced_q != '1)) begin
        forced_q <= forced_q + 1'b1;
      end
    end
  end

  assign oConflictCount   = conf_q;
  assign oForcedRotations = forced_q;
`endif

endmodule

// File: tb/tb_tmem_bank_scheduler.sv
// Self-checking bench for tmem_bank_scheduler: vector table,
// directed corner sequences and randomized run against a model.
module tb_tmem_bank_scheduler;

  localparam int N     = 4;
  localparam int MH    = 4;
  localparam int BOUND = (N - 1) * MH + 1;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iEnable;
  logic [3:0] iRequest;
  logic [3:0] oGrant;
  logic [1:0] oBusSelect;
  logic       oGrantValid;
`ifdef TMEM_SCHED_STATS_EN
  logic        iStatClear;
  logic [15:0] oConflictCount;
  logic [15:0] oForcedRotations;
`endif

  int checks = 0;
  int errors = 0;

  int m_gnt = -1;
  int m_sel = 0;
  int m_ptr = 0;
  int m_hold = 0;
  int m_conf = 0;
  int m_forced = 0;

  always #5 Clock = ~Clock;

  tmem_bank_scheduler #(
    .NUM_CORES (4),
    .CORE_BITS (2),
    .MAX_HOLD  (4)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .iEnable          (iEnable),
    .iRequest         (iRequest),
`ifdef TMEM_SCHED_STATS_EN
    .iStatClear       (iStatClear),
    .oConflictCount   (oConflictCount),
    .oForcedRotations (oForcedRotations),
`endif
    .oGrant           (oGrant),
    .oBusSelect       (oBusSelect),
    .oGrantValid      (oGrantValid)
  );

  function automatic bit has(logic [3:0] m, int j);
    return ((m >> j) & 4'b1) != 4'b0;
  endfunction

  function automatic int first_from(int start, logic [3:0] m);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (start + i) % N;
      if (has(m, j)) return j;
    end
    return -1;
  endfunction

  task automatic model_step(bit r, bit e, logic [3:0] q, bit clr);
    int k;
    logic [3:0] oth;
    if (!r) begin
      m_gnt = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
      m_conf = 0; m_forced = 0;
      return;
    end
    if ($countones(q) >= 2 && m_conf < 65535) m_conf++;
    if (m_gnt < 0) begin
      if (e && q != 4'b0) begin
        m_gnt = first_from(m_ptr, q);
        m_sel = m_gnt;
        m_hold = 1;
      end
    end else begin
      k = m_gnt;
      oth = q & ~(4'b1 << k);
      if (!has(q, k)) begin
        m_ptr = (k + 1) % N;
        if (e && oth != 4'b0) begin
          m_gnt = first_from(k + 1, oth);
          m_sel = m_gnt;
          m_hold = 1;
        end else begin
          m_gnt = -1;
          m_hold = 0;
        end
      end else if (e && oth != 4'b0 && m_hold == MH) begin
        m_ptr = (k + 1) % N;
        m_gnt = first_from(k + 1, oth);
        m_sel = m_gnt;
        m_hold = 1;
        if (m_forced < 65535) m_forced++;
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
    if (clr) begin
      m_conf = 0;
      m_forced = 0;
    end
  endtask

  task automatic drive(bit r, bit e, logic [3:0] q, bit clr);
    Reset = r;
    iEnable = e;
    iRequest = q;
`ifdef TMEM_SCHED_STATS_EN
    iStatClear = clr;
`endif
    model_step(r, e, q, clr);
    @(posedge Clock);
    #1;
  endtask

  task automatic check_model(string name);
    logic [3:0] eg;
    eg = (m_gnt < 0) ? 4'b0 : (4'b1 << m_gnt);
    checks++;
    if (oGrant !== eg || oBusSelect !== 2'(m_sel) ||
        oGrantValid !== (m_gnt >= 0)) begin
      errors++;
      $display("FAIL %s: grant=%b sel=%0d valid=%b, expected grant=%b sel=%0d valid=%b",
               name, oGrant, oBusSelect, oGrantValid,
               eg, m_sel, (m_gnt >= 0));
    end
`ifdef TMEM_SCHED_STATS_EN
    checks++;
    if (oConflictCount !== 16'(m_conf) ||
        oForcedRotations !== 16'(m_forced)) begin
      errors++;
      $display("FAIL %s stats: conf=%0d forced=%0d, expected conf=%0d forced=%0d",
               name, oConflictCount, oForcedRotations,
               m_conf, m_forced);
    end
`endif
  endtask

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [3:0] req;
    logic [3:0] g;
    int         s;
    bit         v;
  } vec_t;

  vec_t tbl[26];

  initial begin
    logic [3:0] q;
    int         waitc[4];
    int         maxw;
    bit         r, e, clr;

    tbl[0]  = '{0, 1, 4'b0000, 4'b0000, 0, 0};
    tbl[1]  = '{1, 1, 4'b0100, 4'b0100, 2, 1};
    tbl[2]  = '{0, 1, 4'b0100, 4'b0000, 0, 0};
    tbl[3]  = '{1, 1, 4'b1010, 4'b0010, 1, 1};
    tbl[4]  = '{1, 1, 4'b1000, 4'b1000, 3, 1};
    tbl[5]  = '{1, 1, 4'b0000, 4'b0000, 3, 0};
    tbl[6]  = '{1, 0, 4'b0011, 4'b0000, 3, 0};
    tbl[7]  = '{1, 0, 4'b0011, 4'b0000, 3, 0};
    tbl[8]  = '{1, 1, 4'b0011, 4'b0001, 0, 1};
    tbl[9]  = '{1, 1, 4'b0101, 4'b0001, 0, 1};
    tbl[10] = '{1, 1, 4'b0101, 4'b0001, 0, 1};
    tbl[11] = '{1, 1, 4'b0101, 4'b0001, 0, 1};
    tbl[12] = '{1, 1, 4'b0101, 4'b0100, 2, 1};
    tbl[13] = '{1, 1, 4'b0101, 4'b0100, 2, 1};
    tbl[14] = '{1, 1, 4'b0101, 4'b0100, 2, 1};
    tbl[15] = '{1, 1, 4'b0101, 4'b0100, 2, 1};
    tbl[16] = '{1, 1, 4'b0101, 4'b0001, 0, 1};
    tbl[17] = '{1, 0, 4'b0101, 4'b0001, 0, 1};
    tbl[18] = '{1, 0, 4'b0101, 4'b0001, 0, 1};
    tbl[19] = '{1, 0, 4'b0101, 4'b0001, 0, 1};
    tbl[20] = '{1, 0, 4'b0101, 4'b0001, 0, 1};
    tbl[21] = '{1, 0, 4'b0101, 4'b0001, 0, 1};
    tbl[22] = '{1, 0, 4'b0100, 4'b0000, 0, 0};
    tbl[23] = '{1, 1, 4'b0100, 4'b0100, 2, 1};
    tbl[24] = '{1, 1, 4'b0000, 4'b0000, 2, 0};
    tbl[25] = '{0, 1, 4'b0000, 4'b0000, 0, 0};

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].req, 1'b0);
      checks++;
      if (oGrant !== tbl[i].g || oBusSelect !== 2'(tbl[i].s) ||
          oGrantValid !== tbl[i].v) begin
        errors++;
        $display("FAIL vec%0d: grant=%b sel=%0d valid=%b, expected grant=%b sel=%0d valid=%b",
                 i, oGrant, oBusSelect, oGrantValid,
                 tbl[i].g, tbl[i].s, tbl[i].v);
      end
    end

    // Lone requester never loses the bank.
    drive(1, 1, 4'b1000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 4'b1000, 1'b0);
      checks++;
      if (oGrant !== 4'b1000) begin
        errors++;
        $display("FAIL solo%0d: grant=%b, expected 1000", i, oGrant);
      end
    end
`ifdef TMEM_SCHED_STATS_EN
    check_val("solo_forced", int'(oForcedRotations), 0);
    check_val("solo_conf", int'(oConflictCount), 0);
    for (int i = 0; i < 10; i++) drive(1, 1, 4'b1111, 1'b0);
    check_val("conf10", int'(oConflictCount), 10);
    check_model("all4");
    drive(1, 1, 4'b1111, 1'b1);
    check_val("clear", int'(oConflictCount), 0);
    check_model("clear_m");
`endif

    // Randomized, enable held high, bounded-wait tracking.
    drive(0, 1, 4'b0000, 1'b0);
    q = 4'b0;
    maxw = 0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) q[b] = ~q[b];
      end
      drive(1, 1, q, 1'b0);
      check_model("rndA");
      for (int b = 0; b < 4; b++) begin
        if (q[b] && !oGrant[b]) waitc[b]++;
        else waitc[b] = 0;
        if (waitc[b] > maxw) maxw = waitc[b];
      end
    end
    checks++;
    if (maxw > BOUND) begin
      errors++;
      $display("FAIL wait_bound: max wait %0d, limit %0d", maxw, BOUND);
    end

    // Fully randomized including reset, enable and stat clear.
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) q[b] = ~q[b];
      end
      r   = ($urandom_range(0, 49) != 0);
      e   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      drive(r, e, q, clr);
      check_model("rndB");
    end

`ifdef TMEM_SCHED_STATS_EN
    drive(1, 1, 4'b1111, 1'b1);
    for (int c = 0; c < 70000; c++) drive(1, 1, 4'b1111, 1'b0);
    check_val("conf_sat", int'(oConflictCount), 65535);
    check_model("sat_m");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmem_bank_scheduler.md
Name: tmem_bank_scheduler

Overview:
- Per-bank TMEM read scheduler. One instance sits in front of each interleaved TMEM bank in the crossbar.
- Shares the bank's single read port among all vector processor cores using rotating-priority round-robin with a bounded hold time.
- Produces a registered one-hot grant plus a binary core index. The index drives the bank's address-row mux; the one-hot grant drives the per-core TMEM_GNT_I lines.
- Replaces the arbiter-plus-grant-delay-flop pair with a single sequenced block. It adds starvation protection and a well-defined re-arbitration timing.

Parameters:
- NUM_CORES, 4, number of requesting cores (≥2).
- CORE_BITS, 2, log2(NUM_CORES), width of the core index.
- MAX_HOLD, 4, maximum consecutive cycles one core may hold the bank while another core is requesting (≥1).

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-low reset.
- iEnable  input  1  when low, no new grants are issued; a current grant is held.
- iRequest  input  NUM_CORES  per-core read request (core's TMEM_CYC_O qualified by bank select).
- oGrant  output  NUM_CORES  registered one-hot grant; all-zero when idle.
- oBusSelect  output  CORE_BITS  registered index of the granted core; drives the address-row mux.
- oGrantValid  output  1  high when oGrant is non-zero.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - oGrant=0, oBusSelect=0, oGrantValid=0.
  - Priority pointer=0, hold counter=0, state=IDLE.
  - Reset mid-grant drops the grant in the next cycle; no request is remembered.
- States: IDLE, GRANT.
- IDLE:
  - If iEnable=1 and iRequest≠0, select the first requesting core scanning upward from the pointer, with wrap-around (pointer, pointer+1 … NUM_CORES-1, 0 …).
  - Register the selection; the grant is visible on the next edge (1-cycle latency, request-to-grant).
  - Go to GRANT with hold counter=1.
- GRANT, with core k granted:
  - iRequest[k]=0 (release): re-arbitrate in the same cycle among the remaining requests, starting at k+1.
    - If any request remains and iEnable=1, the new grant appears next cycle with no idle bubble.
    - Otherwise go to IDLE and clear oGrant.
    - Pointer ← k+1 mod NUM_CORES.
  - iRequest[k]=1, hold counter==MAX_HOLD, and another core requesting: forced rotation. Grant the next requester after k; pointer ← k+1.
  - iRequest[k]=1, no competitor: hold the grant; hold counter saturates at MAX_HOLD.
  - Otherwise: hold the grant and increment the hold counter.
- iEnable=0:
  - Existing grant is held until released, then go to IDLE.
  - Forced rotation is suppressed.
- oBusSelect:
  - Always equals the index of the set bit in oGrant.
  - Retains its last value when idle, so the mux does not toggle.
- Invariants:
  - oGrant is never multi-hot.
  - A grant is only issued to a core whose request was high in the arbitration cycle.
  - Worst-case wait for any continuously requesting core is (NUM_CORES-1)·MAX_HOLD + 1 cycles.
- Simultaneous release by k and new request by k in the same cycle: treated as a release; k has the lowest priority in that arbitration.
- Pointer wrap: NUM_CORES-1 + 1 → 0.

Optional Feature:
- Macro: TMEM_SCHED_STATS_EN.
- When defined, the block adds:
  - Input iStatClear (1 bit).
  - Output oConflictCount (16 bits): increments once per cycle in which ≥2 request bits are high. Saturates at 0xFFFF.
  - Output oForcedRotations (16 bits): increments on each forced rotation. Saturates at 0xFFFF.
  - Both counters clear on reset or on iStatClear=1; clear takes priority over increment.
- When not defined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared definitions file (alongside the existing global defines):
  - Default core count, core-index width, MAX_HOLD default.
  - State encoding constants: IDLE=1'b0, GRANT=1'b1.
  - Stats counter width (16).
- One sub-module: rr_priority_pick.
  - Purely combinational.
  - Takes the request vector, pointer and an exclude mask.
  - Returns a one-hot selection, a binary index, and a found flag.
  - Reused for both IDLE arbitration and release/rotation arbitration.

Test Plan:
- Reset then iRequest=4'b0100 held → cycle+1 oGrant=4'b0100, oBusSelect=2, oGrantValid=1; after Reset=0 for one cycle → all outputs 0.
- Pointer=0, iRequest=4'b1010 at the same cycle → oGrant=4'b0010; core1 releases → next cycle oGrant=4'b1000 (no bubble), oBusSelect=3.
- Core0 held continuously, core2 requesting, MAX_HOLD=4 → core0 granted exactly 4 cycles, then oGrant=4'b0100; core0 is regranted only after core2 releases or its own 4-cycle limit expires.
- Single requester core3 held for 20 cycles → grant stays 4'b1000 throughout; with stats enabled, oForcedRotations=0 and oConflictCount=0.
- iEnable=0 with iRequest=4'b0011 from IDLE → oGrant stays 0; iEnable→1 → next cycle oGrant=4'b0001.
- Stats: all 4 cores requesting for 10 cycles → oConflictCount=10; iStatClear pulse → 0 the next cycle; force 70000 conflict cycles → counter holds at 0xFFFF.
